// File: rtl/qam_mod_param.sv
// qam_mod_param
// Streaming QAM modulator for QPSK, 16-QAM and 64-QAM.
// Each accepted symbol is Gray-mapped to signed I/Q levels. The module then
// emits a 4-phase digital carrier (I, Q, -I, -Q) for SPS clocks per symbol.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   din          symbol bits: upper K = I Gray code, lower K = Q Gray code
//   din_valid    din holds a valid symbol
//   din_ready    combinational; symbol is accepted this cycle when valid
//   clr_underrun synchronous clear of the sticky underrun flag
//   clk_m        symbol clock, high during the first half of each symbol
//   m_align      one-cycle pulse on the first cycle of each symbol
//   i_lvl/q_lvl  signed levels of the symbol being transmitted
//   A_reg        signed carrier sample
//   active       a symbol is being transmitted
//   underrun     sticky; stream starved at a symbol boundary
//
// state | meaning
// IDLE  | no symbol in flight, outputs held at 0, ready for a symbol
// RUN   | transmitting a symbol, cnt walks 0..SPS-1
module qam_mod_param #(
  parameter int BITS_PER_SYM = 4,
  parameter int SPS          = 8,
  localparam int K           = BITS_PER_SYM / 2,
  localparam int LVL_W       = K + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BITS_PER_SYM-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    clr_underrun,
  output logic                    clk_m,
  output logic                    m_align,
  output logic signed [LVL_W-1:0] i_lvl,
  output logic signed [LVL_W-1:0] q_lvl,
  output logic signed [LVL_W-1:0] A_reg,
  output logic                    active,
  output logic                    underrun
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SPS / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [LVL_W-1:0] i_d, q_d, a_d;
  logic                    clk_m_d, m_align_d, underrun_d;
  logic                    accept;

  // Gray -> binary, then level = 2*b + 1 - 2^K. In K+1 bits that is
  // {b, 1} with the MSB flipped, so no wide arithmetic is needed.
  function automatic logic signed [LVL_W-1:0] gray_to_lvl(input logic [K-1:0] g);
    logic [K-1:0] b;
    b[K-1] = g[K-1];
    for (int j = K - 2; j >= 0; j--) begin
      b[j] = b[j+1] ^ g[j];
    end
    return {b, 1'b1} ^ {1'b1, {K{1'b0}}};
  endfunction

  assign din_ready = (state_q == IDLE) || (cnt_q == CNT_LAST);
  assign accept    = din_valid && din_ready;
  assign active    = (state_q == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      i_lvl    <= '0;
      q_lvl    <= '0;
      A_reg    <= '0;
      clk_m    <= 1'b0;
      m_align  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_lvl    <= i_d;
      q_lvl    <= q_d;
      A_reg    <= a_d;
      clk_m    <= clk_m_d;
      m_align  <= m_align_d;
      underrun <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    i_d        = i_lvl;
    q_d        = q_lvl;
    a_d        = A_reg;
    clk_m_d    = clk_m;
    m_align_d  = 1'b0;
    underrun_d = underrun;

    if (clr_underrun) begin
      underrun_d = 1'b0;
    end

    if (accept) begin
      // Covers both the start from idle and the seamless reload at cnt==SPS-1.
      state_d   = RUN;
      cnt_d     = '0;
      i_d       = gray_to_lvl(din[BITS_PER_SYM-1:K]);
      q_d       = gray_to_lvl(din[K-1:0]);
      a_d       = i_d;
      clk_m_d   = 1'b1;
      m_align_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            // Boundary with nothing to send: starve, set wins over clear.
            state_d    = IDLE;
            cnt_d      = '0;
            i_d        = '0;
            q_d        = '0;
            a_d        = '0;
            clk_m_d    = 1'b0;
            underrun_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            // SPS is a multiple of 4, so the low two bits are the phase.
            case (cnt_d[1:0])
              2'd0:    a_d = i_lvl;
              2'd1:    a_d = q_lvl;
              2'd2:    a_d = -i_lvl;
              default: a_d = -q_lvl;
            endcase
            clk_m_d = (cnt_d < CNT_HALF);
          end
        end
        default: begin
          cnt_d   = '0;
          i_d     = '0;
          q_d     = '0;
          a_d     = '0;
          clk_m_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qam_mod_param.sv
// Directed bench for qam_mod_param in three configurations:
//   u_a: 16-QAM, SPS=8 (defaults)
//   u_b: 64-QAM, SPS=4
//   u_c: QPSK,   SPS=4
module tb_qam_mod_param;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  logic              rst_a, valid_a, ready_a, clr_a, clk_m_a, m_align_a, active_a, underrun_a;
  logic [3:0]        din_a;
  logic signed [2:0] i_a, q_a, a_a;

  logic              rst_b, valid_b, ready_b, clr_b, clk_m_b, m_align_b, active_b, underrun_b;
  logic [5:0]        din_b;
  logic signed [3:0] i_b, q_b, a_b;

  logic              rst_c, valid_c, ready_c, clr_c, clk_m_c, m_align_c, active_c, underrun_c;
  logic [1:0]        din_c;
  logic signed [1:0] i_c, q_c, a_c;

  qam_mod_param u_a (
    .clk(clk), .rst(rst_a), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .clr_underrun(clr_a), .clk_m(clk_m_a), .m_align(m_align_a), .i_lvl(i_a),
    .q_lvl(q_a), .A_reg(a_a), .active(active_a), .underrun(underrun_a)
  );

  qam_mod_param #(.BITS_PER_SYM(6), .SPS(4)) u_b (
    .clk(clk), .rst(rst_b), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .clr_underrun(clr_b), .clk_m(clk_m_b), .m_align(m_align_b), .i_lvl(i_b),
    .q_lvl(q_b), .A_reg(a_b), .active(active_b), .underrun(underrun_b)
  );

  qam_mod_param #(.BITS_PER_SYM(2), .SPS(4)) u_c (
    .clk(clk), .rst(rst_c), .din(din_c), .din_valid(valid_c), .din_ready(ready_c),
    .clr_underrun(clr_c), .clk_m(clk_m_c), .m_align(m_align_c), .i_lvl(i_c),
    .q_lvl(q_c), .A_reg(a_c), .active(active_c), .underrun(underrun_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag, input logic exp_underrun);
    chk({tag, "_active"},   active_a, 0);
    chk({tag, "_a_reg"},    $signed(a_a), 0);
    chk({tag, "_i"},        $signed(i_a), 0);
    chk({tag, "_q"},        $signed(q_a), 0);
    chk({tag, "_clk_m"},    clk_m_a, 0);
    chk({tag, "_m_align"},  m_align_a, 0);
    chk({tag, "_ready"},    ready_a, 1);
    chk({tag, "_underrun"}, underrun_a, exp_underrun);
  endtask

  // Called on the first cycle of a symbol; walks its 8 samples and ends on
  // the first cycle after the symbol. nd/nv are driven after cycle 0,
  // nclr is driven during the last cycle.
  task automatic sym_a(input string tag, input int ei, input int eq,
                       input logic [3:0] nd, input logic nv, input logic nclr);
    int exp_a[4];
    exp_a = '{ei, eq, -ei, -eq};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_A%0d", tag, k),     $signed(a_a), exp_a[k % 4]);
      chk($sformatf("%s_align%0d", tag, k), m_align_a, (k == 0));
      chk($sformatf("%s_clkm%0d", tag, k),  clk_m_a, (k < 4));
      chk($sformatf("%s_ready%0d", tag, k), ready_a, (k == 7));
      chk($sformatf("%s_act%0d", tag, k),   active_a, 1);
      chk($sformatf("%s_i%0d", tag, k),     $signed(i_a), ei);
      chk($sformatf("%s_q%0d", tag, k),     $signed(q_a), eq);
      if (k == 0) begin
        din_a   = nd;
        valid_a = nv;
      end
      if (k == 7) clr_a = nclr;
      tick();
    end
    clr_a = 1'b0;
  endtask

  initial begin
    int exp_b[4];
    int ci[4];
    int cq[4];
    int exp_c[4];

    rst_a = 0; valid_a = 0; clr_a = 0; din_a = '0;
    rst_b = 0; valid_b = 0; clr_b = 0; din_b = '0;
    rst_c = 0; valid_c = 0; clr_c = 0; din_c = '0;
    tick();
    tick();
    chk_idle_a("rst", 0);

    rst_a = 1; rst_b = 1; rst_c = 1;
    tick(); tick(); tick();
    chk_idle_a("idle_after_rst", 0);

    // 1101 -> (+1,-1), then back-to-back 1000 -> (+3,-3), 0010 -> (-3,+3).
    din_a = 4'b1101; valid_a = 1;
    tick();
    sym_a("t1",   1, -1, 4'b1000, 1'b1, 1'b0);
    sym_a("t2a",  3, -3, 4'b0010, 1'b1, 1'b0);
    sym_a("t2b", -3,  3, 4'b0000, 1'b0, 1'b0);
    chk_idle_a("starve", 1);
    tick();
    chk("underrun_sticky", underrun_a, 1);
    clr_a = 1;
    tick();
    clr_a = 0;
    chk("underrun_clr", underrun_a, 0);

    // Clear requested on the very cycle a new starvation is flagged.
    din_a = 4'b1101; valid_a = 1;
    tick();
    sym_a("t3", 1, -1, 4'b0000, 1'b0, 1'b1);
    chk_idle_a("set_beats_clr", 1);

    // Reset mid-symbol at cnt==5, while underrun is still set.
    din_a = 4'b1000; valid_a = 1;
    tick();
    chk("mid_align0", m_align_a, 1);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_a5", $signed(a_a), -3);
    chk("mid_clkm5", clk_m_a, 0);
    rst_a = 0;
    #1;
    chk_idle_a("mid_rst", 0);
    tick();
    tick();
    rst_a = 1;
    tick();
    chk("post_rst_align", m_align_a, 1);
    chk("post_rst_a", $signed(a_a), 3);
    chk("post_rst_i", $signed(i_a), 3);
    chk("post_rst_q", $signed(q_a), -3);
    chk("post_rst_act", active_a, 1);
    chk("post_rst_clkm", clk_m_a, 1);
    chk("post_rst_underrun", underrun_a, 0);
    valid_a = 0;

    // 64-QAM, SPS=4: 100_000 -> (+7,-7), full-scale negation in 4 bits.
    exp_b = '{7, -7, -7, 7};
    din_b = 6'b100000; valid_b = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b_A%0d", k),     $signed(a_b), exp_b[k]);
      chk($sformatf("b_i%0d", k),     $signed(i_b), 7);
      chk($sformatf("b_q%0d", k),     $signed(q_b), -7);
      chk($sformatf("b_align%0d", k), m_align_b, (k == 0));
      chk($sformatf("b_clkm%0d", k),  clk_m_b, (k < 2));
      chk($sformatf("b_ready%0d", k), ready_b, (k == 3));
      if (k == 0) valid_b = 0;
      tick();
    end
    chk("b_end_act", active_b, 0);
    chk("b_end_a", $signed(a_b), 0);
    chk("b_end_underrun", underrun_b, 1);

    // QPSK, SPS=4: sweep 00,01,10,11 back to back.
    ci = '{-1, -1, 1, 1};
    cq = '{-1, 1, -1, 1};
    din_c = 2'b00; valid_c = 1;
    tick();
    for (int s = 0; s < 4; s++) begin
      exp_c = '{ci[s], cq[s], -ci[s], -cq[s]};
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("c%0d_A%0d", s, k),     $signed(a_c), exp_c[k]);
        chk($sformatf("c%0d_i%0d", s, k),     $signed(i_c), ci[s]);
        chk($sformatf("c%0d_q%0d", s, k),     $signed(q_c), cq[s]);
        chk($sformatf("c%0d_align%0d", s, k), m_align_c, (k == 0));
        chk($sformatf("c%0d_clkm%0d", s, k),  clk_m_c, (k < 2));
        if (k == 3) begin
          if (s < 3) din_c = 2'(s + 1);
          else       valid_c = 0;
        end
        tick();
      end
    end
    chk("c_end_act", active_c, 0);
    chk("c_end_a", $signed(a_c), 0);
    chk("c_end_underrun", underrun_c, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qam_mod_param.md
Name: qam_mod_param

Overview:
Parametrised successor of the fixed-size digital QAM modulator. Accepts a symbol stream over a valid/ready handshake and Gray-maps each symbol to signed I/Q levels for QPSK, 16-QAM or 64-QAM. Produces a 4-phase digital-carrier sample stream (I, Q, -I, -Q) plus a symbol clock and a symbol-alignment pulse. Sits between the symbol source and the DAC/sample sink.

Parameters:
BITS_PER_SYM, 4, bits per symbol; legal values 2, 4, 6 (QPSK, 16-QAM, 64-QAM). K = BITS_PER_SYM/2 bits per axis.
SPS, 8, clock cycles per symbol; multiple of 4, at least 4.
LVL_W (localparam), K+1, signed width of level and sample outputs.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
din  in  BITS_PER_SYM  symbol bits; upper K bits = I Gray code, lower K bits = Q Gray code.
din_valid  in  1  din holds a valid symbol.
din_ready  out  1  combinational; module accepts din this cycle.
clr_underrun  in  1  synchronous clear of the underrun flag.
clk_m  out  1  symbol clock; high for cnt < SPS/2 while active, low while idle.
m_align  out  1  one-cycle pulse on cnt==0 of each symbol.
i_lvl  out  LVL_W  signed I level of the current symbol.
q_lvl  out  LVL_W  signed Q level of the current symbol.
A_reg  out  LVL_W  signed carrier sample.
active  out  1  a symbol is being transmitted.
underrun  out  1  sticky; stream starved mid-transmission.

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, active=0, clk_m=0, m_align=0, i_lvl=q_lvl=A_reg=0, underrun=0. All outputs except din_ready are registered.
- din_ready = !active | (cnt==SPS-1).
- Accept: din_valid & din_ready. On the next edge:
  - cnt=0, active=1, m_align=1.
  - i_lvl and q_lvl load the mapped levels.
  - A_reg = new I level (phase 0).
  - clk_m=1.
- Mapping per axis: Gray g (K bits) -> binary b (b[K-1]=g[K-1], b[j]=b[j+1]^g[j]). Level = 2*b - (2^K - 1), an odd integer in ±(2^K - 1).
  - K=2: 00->-3, 01->-1, 11->+1, 10->+3.
  - K=1: 0->-1, 1->+1.
- While active and no accept: cnt increments by 1; phase p = cnt mod 4.
  - A_reg = i_lvl (p=0), q_lvl (p=1), -i_lvl (p=2), -q_lvl (p=3).
  - Negation never overflows LVL_W.
  - m_align=0; clk_m = (cnt_next < SPS/2).
- Boundary, cnt==SPS-1 with active=1:
  - Valid symbol present: seamless reload, no gap cycle. cnt wraps to 0, carrier phase restarts at 0.
  - No valid symbol: next cycle active=0, cnt=0, clk_m=0, m_align=0, i_lvl=q_lvl=A_reg=0, and underrun is set.
- Idle (active=0):
  - Outputs hold at 0; din_ready=1.
  - The first accepted symbol starts the stream and does not set underrun.
  - A starting idle state (after reset) never sets underrun.
- underrun: cleared by clr_underrun on the next edge. If a set and clr_underrun occur in the same cycle, set wins.
- din_valid while din_ready=0: ignored. Source must hold din/din_valid until the handshake.
- Reset asserted mid-symbol: all state clears immediately. The first symbol after release starts at cnt=0 with m_align.
- Latency: handshake edge to first sample on A_reg = 1 clock.

Test Plan:
- Reset then din=4'b1101 held valid (defaults): one cycle after handshake, m_align=1, i_lvl=+1, q_lvl=-1. A_reg over 8 cycles = +1,-1,-1,+1,+1,-1,-1,+1. clk_m high for cycles 0-3, low for 4-7.
- Back-to-back symbols 4'b1000 then 4'b0010: A_reg = +3,-3,-3,+3 x2, then -3,+3,+3,-3 x2. m_align pulses exactly 8 cycles apart. din_ready high only at cnt==7.
- Valid drops after one symbol: after 8 samples, active=0, A_reg=0, clk_m=0, underrun=1. clr_underrun pulse -> underrun=0. Asserting clr_underrun together with a new starvation leaves underrun=1.
- BITS_PER_SYM=6, SPS=4, din=6'b100_000: i_lvl=+7, q_lvl=-7. A_reg = +7,-7,-7,+7, with no overflow of the 4-bit signed output.
- BITS_PER_SYM=2, SPS=4, din sweep 00,01,10,11: (I,Q) = (-1,-1), (-1,+1), (+1,-1), (+1,+1). Check each phase sequence.
- rst pulsed low at cnt==5 mid-symbol: all outputs 0 immediately, underrun=0. After release, the next valid symbol starts with m_align at cnt=0.
